fetch_unit: RTL and testbench
=============================

# fetch_unit

- Instruction fetch and PC sequencer for the RISC-V core. Sits directly upstream of the control unit.
- Owns the program counter and fetches from instruction memory over a ready-handshake interface.
- Holds the fetched instruction stable (opcode bits [6:0] feed the control unit) until the datapath retires it.
- Computes the next PC from the control unit's Branch/Jump/Jalr decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction to decode/control unit.
- instr_valid  out  1  instr is valid and executing.
- pc  out  32  PC of the held instruction.
- pc_plus4  out  32  pc + 4, combinational; link value for JAL/JALR.
- retire  in  1  datapath completes the held instruction this cycle.
- branch  in  1  Branch decode from the control unit.
- jump  in  1  Jump (JAL) decode from the control unit.
- jalr  in  1  Jalr decode from the control unit.
- br_cond  in  1  branch comparison satisfied (from ALU compare / ALU_zero logic).
- imm  in  32  sign-extended B/J immediate.
- jalr_target  in  32  ALU result rs1 + imm for JALR.
- misalign_trap  out  1  fetch target misaligned (meaningful only with the feature macro).

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, immediate):
  - pc = RESET_PC, state = IDLE.
  - imem_req = 0, instr_valid = 0, misalign_trap = 0.
  - instr = 32'h0000_0013 (NOP).
- IDLE → FETCH unconditionally on the next edge.
- FETCH:
  - imem_req = 1; imem_addr = pc, held stable.
  - On an edge with imem_ready = 1: instr ← imem_rdata, instr_valid ← 1, → EXEC.
  - Otherwise remain in FETCH (unbounded wait states).
- EXEC:
  - instr_valid = 1, imem_req = 0.
  - Redirect inputs are sampled only on an edge with retire = 1. On that edge: pc ← next_pc, instr_valid ← 0, → FETCH.
- next_pc priority:
  - jalr: {jalr_target[31:1], 1'b0}.
  - else jump, or (branch & br_cond): pc + imm.
  - else pc + 4.
- Arithmetic: 32-bit modulo 2^32; wrap-around from 32'hFFFF_FFFC + 4 gives 32'h0000_0000.
- imem_ready outside FETCH is ignored. retire outside EXEC is ignored.
- Multiple decode flags set at once: the priority above applies, no error.
- Reset asserted mid-FETCH: imem_req drops immediately; any later imem_ready is ignored until the next FETCH.

## Timing
- Reset release: edge 1 → FETCH; imem_req high in that cycle.
- Fetch latency: capture on the first edge with imem_ready high; instr_valid rises the cycle after.
- Minimum throughput: 2 cycles per instruction (FETCH 1 cycle + EXEC ≥1 cycle).
- pc, instr and instr_valid are registered. pc_plus4 and imem_addr are combinational from pc.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - On a retire edge, if next_pc[1] = 1: pc is still updated, misalign_trap ← 1, → HALT.
  - HALT: imem_req = 0, instr_valid = 0, retire ignored.
  - misalign_trap stays 1 until reset; exit only by reset.
- Not defined:
  - next_pc[1:0] forced to 2'b00 silently.
  - misalign_trap tied to 0; HALT unreachable.

## Test plan
- Reset, RESET_PC = 32'h100, imem_ready = 1 always → imem_addr = 0x100 one cycle after release; instr_valid rises next cycle; pc = 0x100.
- Sequential flow: retire pulses, no redirects → fetch addresses 0x100, 0x104, 0x108; pc_plus4 = 0x104 while pc = 0x100.
- Branch taken at pc = 0x200, imm = 32'hFFFF_FFF0, branch = 1, br_cond = 1 → next imem_addr = 0x1F0. Same with br_cond = 0 → 0x204.
- JALR with jalr_target = 0x301 and jump = 1 asserted together → jalr wins; imem_addr = 0x300.
- imem_ready low for 3 FETCH cycles → imem_req held, imem_addr stable, instr_valid low; capture on the 4th.
- Macro defined, jalr_target = 0x302 → misalign_trap = 1, imem_req stays 0. Reset asserted mid-FETCH → imem_req drops the same cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer: fetches over a ready handshake, holds the word for decode, redirects on retire.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned fetch target traps and halts instead of being silently aligned.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic        br_cond,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_target,
  output logic        misalign_trap
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] JALR_MASK  = ~XLEN'(1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            target_misaligned;

  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // Redirect priority: jalr over jump/taken branch over sequential.
  always_comb begin
    target = pc_plus4;
    if (jalr) begin
      target = jalr_target & JALR_MASK;
    end else if (jump || (branch && br_cond)) begin
      target = pc + imm;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc           = target;
  assign target_misaligned = target[1];
`else
  assign next_pc           = target & ALIGN_MASK;
  assign target_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      instr         <= NOP_INSTR;
      instr_valid   <= 1'b0;
      imem_req      <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            if (target_misaligned) begin
              misalign_trap <= 1'b1;
              imem_req      <= 1'b0;
              state         <= HALT;
            end else begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a per-cycle reference model and literal spot checks.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] MOD32    = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire, branch, jump, jalr, br_cond;
  logic [31:0] imm;
  logic [31:0] jalr_target;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .retire(retire), .branch(branch), .jump(jump), .jalr(jalr), .br_cond(br_cond),
    .imm(imm), .jalr_target(jalr_target), .misalign_trap(misalign_trap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the core is doing (waiting, executing, halted) and what it holds.
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
  int          m_phase;
  logic [31:0] m_pc, m_instr;
  logic        m_trap;

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
    return 32'((64'(a) + 64'(b)) % MOD32);
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] t;
    if (reset) begin
      m_phase = P_IDLE; m_pc = RESET_PC; m_instr = NOP; m_trap = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE:  m_phase = P_FETCH;
        P_FETCH: if (imem_ready) begin m_instr = imem_rdata; m_phase = P_EXEC; end
        P_EXEC: if (retire) begin
          if (jalr)                           t = jalr_target - (jalr_target % 2);
          else if (jump || (branch && br_cond)) t = add32(m_pc, imm);
          else                                t = add32(m_pc, 32'd4);
`ifdef FETCH_MISALIGN_TRAP_EN
          m_pc = t;
          if ((t / 2) % 2 == 1) begin m_trap = 1'b1; m_phase = P_HALT; end
          else m_phase = P_FETCH;
`else
          m_pc = t - (t % 4);
          m_phase = P_FETCH;
`endif
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_req",   32'(imem_req),      32'(m_phase == P_FETCH));
      chk("cyc_valid", 32'(instr_valid),   32'(m_phase == P_EXEC));
      chk("cyc_addr",  imem_addr,          m_pc);
      chk("cyc_pc",    pc,                 m_pc);
      chk("cyc_pc4",   pc_plus4,           add32(m_pc, 32'd4));
      chk("cyc_instr", instr,              m_instr);
      chk("cyc_trap",  32'(misalign_trap), 32'(m_trap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_retire(input logic b, input logic j, input logic jr, input logic c,
                           input logic [31:0] im, input logic [31:0] tgt);
    branch = b; jump = j; jalr = jr; br_cond = c; imm = im; jalr_target = tgt; retire = 1'b1;
    tick();
    branch = 0; jump = 0; jalr = 0; br_cond = 0; imm = 0; jalr_target = 0; retire = 0;
  endtask

  initial begin
    reset = 1; imem_ready = 1; imem_rdata = 32'h00A0_0093;
    retire = 0; branch = 0; jump = 0; jalr = 0; br_cond = 0; imm = 0; jalr_target = 0;
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst_pc",    pc,                 32'h100);
    chk("rst_instr", instr,              NOP);
    chk("rst_valid", 32'(instr_valid),   32'h0);
    chk("rst_req",   32'(imem_req),      32'h0);
    chk("rst_trap",  32'(misalign_trap), 32'h0);

    reset = 0;
    tick();
    chk("first_req",   32'(imem_req),    32'h1);
    chk("first_addr",  imem_addr,        32'h100);
    chk("first_valid", 32'(instr_valid), 32'h0);
    tick();
    chk("cap_valid", 32'(instr_valid), 32'h1);
    chk("cap_instr", instr,            32'h00A0_0093);
    chk("cap_pc4",   pc_plus4,         32'h104);

    // sequential flow
    do_retire(0, 0, 0, 0, 0, 0);
    chk("seq_addr1", imem_addr, 32'h104);
    imem_rdata = 32'h0010_0113;
    tick();
    do_retire(0, 0, 0, 0, 0, 0);
    chk("seq_addr2", imem_addr, 32'h108);
    tick();
    do_retire(0, 1, 0, 0, 32'h0000_00F8, 0);
    chk("jal_addr", imem_addr, 32'h200);
    tick();

    // branch taken / not taken at 0x200
    do_retire(1, 0, 0, 1, 32'hFFFF_FFF0, 0);
    chk("br_taken", imem_addr, 32'h1F0);
    tick();
    do_retire(0, 1, 0, 0, 32'h0000_0010, 0);
    tick();
    do_retire(1, 0, 0, 0, 32'hFFFF_FFF0, 0);
    chk("br_not_taken", imem_addr, 32'h204);
    tick();

    // jalr wins over jump, then a 3-cycle memory stall
    do_retire(0, 1, 1, 0, 32'h0000_0040, 32'h301);
    imem_ready = 0;
    chk("jalr_prio", imem_addr, 32'h300);
    for (int i = 0; i < 3; i++) begin
      retire = (i == 1);
      tick();
      chk("stall_req",   32'(imem_req),    32'h1);
      chk("stall_addr",  imem_addr,        32'h300);
      chk("stall_valid", 32'(instr_valid), 32'h0);
    end
    retire = 0;
    imem_ready = 1; imem_rdata = 32'h0000_0033;
    tick();
    chk("stall_cap", 32'(instr_valid), 32'h1);

    // wrap-around
    do_retire(0, 0, 1, 0, 0, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc4", pc_plus4, 32'h0);
    do_retire(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // reset asserted in the middle of a stalled fetch
    imem_ready = 0;
    tick();
    #2 reset = 1;
    #1 chk("mid_rst_req", 32'(imem_req), 32'h0);
    imem_ready = 1;
    tick(); tick();
    chk("rst_hold_valid", 32'(instr_valid), 32'h0);
    chk("rst_hold_pc",    pc,               32'h100);
    reset = 0;
    tick();
    chk("refetch_valid", 32'(instr_valid), 32'h0);
    tick();

    // misaligned jalr target
    do_retire(0, 0, 1, 0, 0, 32'h302);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_trap", 32'(misalign_trap), 32'h1);
    chk("mis_req",  32'(imem_req),      32'h0);
    retire = 1;
    tick(); tick();
    retire = 0;
    chk("halt_req",   32'(imem_req),    32'h0);
    chk("halt_valid", 32'(instr_valid), 32'h0);
`else
    chk("mis_addr", imem_addr,          32'h300);
    chk("mis_trap", 32'(misalign_trap), 32'h0);
    tick();
    chk("mis_valid", 32'(instr_valid), 32'h1);
`endif
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
